// File: rtl/prng_seq_checker.sv
// Receive-side checker for the bit-reversed 4-bit LFSR nibble stream:
// self-synchronises a local LFSR copy, then flywheels it to flag and count corrupted nibbles.
module prng_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       data_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pred_q, pred_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [3:0]       r;
  logic             hit;
  logic             count_err;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    count_err   = 1'b0;

    // Wire bit i carries generator bit 3-i.
    r         = {data_in[0], data_in[1], data_in[2], data_in[3]};
    hit       = (r == pred_q) && (r != 4'd0);
    match_inc = match_cnt_q + MW'(1);
    miss_inc  = miss_cnt_q + LW'(1);

    if (valid_in) begin
      if (state_q == SEARCH) begin
        pred_d      = lfsr_next(r);
        match_cnt_d = hit ? match_inc : '0;
        if (hit && (match_inc == MW'(LOCK_CNT))) begin
          state_d    = LOCKED;
          miss_cnt_d = '0;
        end
      end else begin
        // Flywheel: while locked the prediction never follows the received data.
        pred_d = lfsr_next(pred_q);
        if (r == pred_q) begin
          miss_cnt_d = '0;
        end else begin
          count_err  = 1'b1;
          miss_cnt_d = miss_inc;
          if (miss_inc == LW'(LOSS_CNT)) begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            pred_d      = lfsr_next(r);
          end
        end
      end
    end

    err_pulse_d = count_err;
    if (clear_err) begin
      err_count_d = ERR_W'(count_err);
    end else if (count_err) begin
      err_count_d = sat_inc(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prng_seq_checker.sv
// Scoreboard bench for prng_seq_checker: directed scenarios plus a randomized stream,
// with expected outputs from a behavioural model of the checker rules.
module tb_prng_seq_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [3:0]  data_in = 4'd0;
  logic        clear_err = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked2, err_pulse2;
  logic [1:0]  err_count2;

  always #5 clk = ~clk;

  prng_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .clear_err(clear_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count));

  prng_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .clear_err(clear_err),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2));

  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [1:0]  ec2;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state.
  bit m_lock, m_pulse;
  int m_pred, m_match, m_miss, m_ec16, m_ec2;
  int g;  // generator state (never zero)

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rev(input int d);
    return ((d & 1) * 8) + (((d / 2) & 1) * 4) + (((d / 4) & 1) * 2) + ((d / 8) & 1);
  endfunction

  function automatic int nxt(input int s);
    return ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
  endfunction

  task automatic model(input bit v, input int d, input bit clr, input bit rs);
    int r;
    bit cnt;
    if (rs) begin
      m_lock = 0; m_pulse = 0; m_pred = 0; m_match = 0; m_miss = 0; m_ec16 = 0; m_ec2 = 0;
      return;
    end
    cnt = 0;
    if (v) begin
      r = rev(d);
      if (!m_lock) begin
        if (r == m_pred && r != 0) m_match++; else m_match = 0;
        m_pred = nxt(r);
        if (m_match == LOCK_CNT) begin m_lock = 1; m_miss = 0; end
      end else begin
        if (r == m_pred) begin
          m_miss = 0;
          m_pred = nxt(m_pred);
        end else begin
          cnt = 1;
          m_miss++;
          m_pred = nxt(m_pred);
          if (m_miss == LOSS_CNT) begin m_lock = 0; m_match = 0; m_pred = nxt(r); end
        end
      end
    end
    m_pulse = cnt;
    if (clr) begin
      m_ec16 = cnt; m_ec2 = cnt;
    end else if (cnt) begin
      if (m_ec16 < 65535) m_ec16++;
      if (m_ec2 < 3) m_ec2++;
    end
  endtask

  task automatic step(input bit v, input logic [3:0] d, input bit clr, input bit rs);
    exp_t e;
    @(negedge clk);
    valid_in = v; data_in = d; clear_err = clr; rst = rs;
    model(v, int'(d), clr, rs);
    e.lk = m_lock; e.ep = m_pulse; e.ec = 16'(m_ec16); e.ec2 = 2'(m_ec2);
    exp_q.push_back(e);
  endtask

  task automatic gen_nib(output logic [3:0] d);
    d = 4'(rev(g));
    g = nxt(g);
  endtask

  task automatic send_clean(input int n);
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      gen_nib(d);
      step(1, d, 0, 0);
    end
  endtask

  task automatic send_bad(input bit clr);
    logic [3:0] d;
    gen_nib(d);
    d = d ^ 4'($urandom_range(1, 15));
    step(1, d, clr, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every consumed cycle produces one registered result.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      chk("sb_locked", 32'(locked), 32'(e_mon.lk));
      chk("sb_err_pulse", 32'(err_pulse), 32'(e_mon.ep));
      chk("sb_err_count", 32'(err_count), 32'(e_mon.ec));
      chk("sb_locked_w2", 32'(locked2), 32'(e_mon.lk));
      chk("sb_err_count_w2", 32'(err_count2), 32'(e_mon.ec2));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    int nv;
    // Reset state
    step(0, 4'd0, 0, 1);
    step(0, 4'd0, 0, 1);
    settle();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);

    // Clean lock on fifth sample: wire nibbles 1000,0100,0010,1001,1100
    g = 1;
    send_clean(4);
    settle();
    chk("t1_not_yet_locked", 32'(locked), 0);
    send_clean(1);
    settle();
    chk("t1_locked", 32'(locked), 1);
    chk("t1_err_count", 32'(err_count), 0);

    // Single error while locked, flywheel recovers
    send_clean(2);
    send_bad(0);
    settle();
    chk("t2_err_pulse", 32'(err_pulse), 1);
    chk("t2_err_count", 32'(err_count), 1);
    chk("t2_locked", 32'(locked), 1);
    send_clean(1);
    settle();
    chk("t2_pulse_clear", 32'(err_pulse), 0);
    chk("t2_still_locked", 32'(locked), 1);
    chk("t2_count_hold", 32'(err_count), 1);

    // Loss of lock after three misses, then relock
    send_bad(0);
    send_bad(0);
    settle();
    chk("t3_locked_after2", 32'(locked), 1);
    send_bad(0);
    settle();
    chk("t3_lost", 32'(locked), 0);
    chk("t3_err_count", 32'(err_count), 4);
    send_clean(5);
    settle();
    chk("t3_relocked", 32'(locked), 1);
    chk("t3_err_count_hold", 32'(err_count), 4);

    // Stuck-zero input never locks
    step(1, 4'd0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 4'd0, 0, 0);
    settle();
    chk("t4_stuck_zero", 32'(locked), 0);
    chk("t4_no_errors", 32'(err_count), 0);

    // Saturation (ERR_W=2) and clear
    step(0, 4'd0, 0, 1);
    g = $urandom_range(1, 15);
    send_clean(5);
    for (int i = 0; i < 4; i++) begin
      send_bad(0);
      send_clean(1);
    end
    send_bad(0);
    settle();
    chk("t5_sat_w2", 32'(err_count2), 3);
    chk("t5_count_w16", 32'(err_count), 5);
    chk("t5_locked", 32'(locked), 1);
    send_bad(1);
    settle();
    chk("t5_clear_with_err_w2", 32'(err_count2), 1);
    chk("t5_clear_with_err_w16", 32'(err_count), 1);
    gen_nib(d);
    step(1, d, 1, 0);
    settle();
    chk("t5_clear_alone", 32'(err_count), 0);
    chk("t5_clear_alone_w2", 32'(err_count2), 0);

    // Gapped clean stream, then reset while locked
    step(0, 4'd0, 0, 1);
    g = $urandom_range(1, 15);
    nv = 0;
    while (nv < 10) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_nib(d);
        step(1, d, 0, 0);
        nv++;
      end else begin
        step(0, 4'($urandom_range(0, 15)), 0, 0);
      end
    end
    settle();
    chk("t6_gap_locked", 32'(locked), 1);
    chk("t6_gap_no_err", 32'(err_count), 0);
    send_bad(0);
    gen_nib(d);
    step(1, d, 0, 1);
    settle();
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_pulse", 32'(err_pulse), 0);
    chk("t6_rst_count", 32'(err_count), 0);

    // Randomized stream: gaps, corruption bursts, zero nibbles, clears, resets, resyncs
    g = $urandom_range(1, 15);
    for (int i = 0; i < 3000; i++) begin
      int sel;
      bit clr, rs;
      clr = ($urandom_range(0, 99) < 3);
      rs  = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 499) == 0) g = $urandom_range(1, 15);
      if ($urandom_range(0, 3) == 0) begin
        step(0, 4'($urandom_range(0, 15)), clr, rs);
      end else begin
        sel = $urandom_range(0, 99);
        gen_nib(d);
        if (sel < 10) d = d ^ 4'($urandom_range(1, 15));
        else if (sel < 12) d = 4'd0;
        step(1, d, clr, rs);
      end
    end
    step(0, 4'd0, 0, 0);
    settle();
    settle();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
